dm_access_ctrl: RTL and testbench
=================================

// Module: dm_access_ctrl
// PURPOSE
// - MEM-stage load/store controller: sits between the pipeline MEM stage and the word-wide data memory port.
// - Turns byte/half/word loads and stores into DM_enable/DM_read/DM_write sequences; sub-word stores use read-modify-write.
// - Stalls the pipeline until each access completes, then returns aligned, extended load data. Flags misalignment, bad resp and timeout.
// PARAMETERS
// - data_size  32  data bus width
// - addr_size  12  DM word-address width; byte address = addr_size+2 bits
// - TIMEOUT    16  max cycles waiting for DM_finish before error
// PORTS
// - clk         in   1             clock
// - rst         in   1             reset; one clock, synchronous, active-high
// - req_valid   in   1             MEM stage holds a load/store; held stable while stall=1
// - req_we      in   1             1=store, 0=load
// - req_size    in   2             0=byte, 1=half, 2=word (3 illegal -> err)
// - req_unsigned in  1             load zero-extend (1) / sign-extend (0)
// - req_addr    in   addr_size+2   byte address
// - req_wdata   in   data_size     store data, right-justified
// - stall       out  1             comb: req_valid && state!=DONE
// - rdata_valid out  1             one-cycle pulse in DONE for loads
// - rdata       out  data_size     extended load data, held until next load completes
// - err         out  1             one-cycle pulse in DONE on error
// - DM_enable/DM_read/DM_write out 1   comb from state, forced 0 while rst=1
// - DM_addr     out  addr_size     registered word address (req_addr[top:2])
// - DM_in       out  data_size     registered store word
// - DM_out      in   data_size     read word, valid while DM_finish=1
// - DM_ready    in   1             ignored (informational)
// - DM_resp     in   2             OKAY=2'b00; anything else = error
// - DM_finish   in   1             access done; first seen the cycle after enable
// BEHAVIOUR
// - Reset: state=IDLE, rdata=0, rdata_valid=0, err=0, DM_addr=0, DM_in=0, timer=0.
// - FSM: IDLE, RD, RWAIT, WR, WWAIT, DONE.
// - IDLE & req_valid:
//   - misaligned (half addr[0]!=0; word addr[1:0]!=0) or size=3 -> DONE with err; no DM access.
//   - load or sub-word store -> RD. Word store -> WR.
//   - Latch DM_addr. For word store, DM_in=req_wdata.
// - RD: DM_enable=DM_read=1 for exactly this cycle -> RWAIT.
// - RWAIT: enable=0; timer++ each cycle.
//   - On DM_finish: DM_resp!=OKAY -> DONE+err.
//   - Else load -> capture extracted/extended DM_out into rdata -> DONE.
//   - Else sub-word store -> DM_in=merge(DM_out,req_wdata,offset) -> WR.
//   - timer==TIMEOUT-1 without finish -> DONE+err.
// - WR: DM_enable=DM_write=1 for one cycle -> WWAIT. WWAIT mirrors RWAIT (finish -> DONE; resp/timeout -> err).
// - DONE: stall=0; rdata_valid=!req_we && !err; -> IDLE; timer cleared.
// - Latency (cycles incl. IDLE and DONE):
//   - word load 4, word store 4, sub-word store 6, misaligned 2.
//   - Back-to-back requests are separated by one IDLE cycle.
// - Little-endian lanes:
//   - byte k = bits[8k+7:8k]; half at offset 0 -> [15:0], offset 2 -> [31:16].
//   - Merge replaces only the addressed lane; other bytes come from DM_out.
// - On error, rdata keeps its previous value; no write is issued after a failed read.
// - req_valid dropping mid-access (illegal): access runs to DONE regardless.
// - rst mid-access: DM controls drop to 0 in the rst cycle, FSM -> IDLE, pending request discarded (pipeline re-issues).
// STRUCTURE
// - dm_pkg: size enum (SZ_B/SZ_H/SZ_W), state enum, HRESP constants OKAY/ERROR/RETRY/SPLIT.
// - Sub-module dm_lane_unit (combinational):
//   - extract: word, offset, size, unsigned -> rdata.
//   - merge: old word, wdata, offset, size -> new word.
// - Top holds the FSM, timer and registers.
// TESTING
// - Word store 0xDEADBEEF @0x010, then word load @0x010:
//   - DM_write seen in cycle 1, rdata=0xDEADBEEF with rdata_valid in cycle 3.
// - Sub-word store: word @0x020=0x11223344.
//   - sb 0xAA @0x021 -> word 0x1122AA44 (one read, then one write).
//   - sh 0xBEEF @0x022 -> 0xBEEFAA44.
// - Loads from 0x80FF7F01 @0x030:
//   - lb @0x030 -> 0x00000001; lb @0x031 -> 0x0000007F; lb @0x032 -> 0xFFFFFFFF.
//   - lbu @0x032 -> 0x000000FF; lh @0x032 -> 0xFFFF80FF.
// - Misaligned lw @0x006 and sh @0x003:
//   - err pulse in cycle 1, DM_enable never asserted, rdata unchanged.
// - Faults:
//   - DM_finish held low -> err after TIMEOUT cycles.
//   - DM_resp=ERROR on read of a sub-word store -> err, no DM_write.
// - rst asserted during WWAIT:
//   - next cycle state IDLE, all outputs at reset values.
//   - new load then completes normally.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types for the MEM-stage data-memory access controller.
//   size_e  : access size encoding carried on req_size
//   state_e : controller FSM states
//   RESP_*  : DM_resp encodings (anything but RESP_OKAY is an error)
package dm_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RWAIT,
    S_WR,
    S_WWAIT,
    S_DONE
  } state_e;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] RESP_RETRY = 2'b10;
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  // Illegal size encoding or an address not aligned to the access size.
  function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = offset[0];
      SZ_W:    bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Little-endian lane steering between a memory word and a sub-word access.
//   dm_word      : word read from memory
//   wdata        : right-justified store data
//   offset, size : byte offset within the word and access size
//   is_unsigned  : zero-extend (1) or sign-extend (0) loaded lanes
//   ext_data_c   : addressed lane, right-justified and extended
//   merge_data_c : dm_word with only the addressed lane replaced by wdata
module dm_lane_unit
  import dm_pkg::*;
#(
  parameter int unsigned data_size = 32
) (
  input  logic [data_size-1:0] dm_word,
  input  logic [data_size-1:0] wdata,
  input  logic [1:0]           offset,
  input  logic [1:0]           size,
  input  logic                 is_unsigned,
  output logic [data_size-1:0] ext_data_c,
  output logic [data_size-1:0] merge_data_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Byte k lives in bits [8k+7:8k]; halves at offset 0 and 2.
  always_comb begin
    byte_v = dm_word[{offset, 3'b000} +: 8];
    half_v = dm_word[{offset[1], 4'b0000} +: 16];
  end

  // Load extraction with sign/zero extension.
  always_comb begin
    ext_data_c = dm_word;
    case (size)
      SZ_B:    ext_data_c = {{(data_size-8){byte_v[7] & ~is_unsigned}}, byte_v};
      SZ_H:    ext_data_c = {{(data_size-16){half_v[15] & ~is_unsigned}}, half_v};
      default: ext_data_c = dm_word;
    endcase
  end

  // Read-modify-write merge: untouched lanes come from the memory word.
  always_comb begin
    merge_data_c = dm_word;
    case (size)
      SZ_B:    merge_data_c[{offset, 3'b000} +: 8]     = wdata[7:0];
      SZ_H:    merge_data_c[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      default: merge_data_c = wdata;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage load/store controller driving a word-wide data memory port.
// Sub-word stores are done as read-modify-write; the pipeline is stalled
// until the access finishes, misaligns, gets a bad response or times out.
//   clk, rst                  : clock, synchronous active-high reset
//   req_*                     : MEM-stage request (valid/we/size/unsigned/addr/wdata)
//   stall                     : combinational hold for the MEM stage
//   rdata_valid, rdata, err   : completion results, registered
//   DM_enable/DM_read/DM_write: memory strobes, decoded from state
//   DM_addr, DM_in            : registered word address and store word
//   DM_out/DM_ready/DM_resp/DM_finish : memory response
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned data_size = 32,
  parameter int unsigned addr_size = 12,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [addr_size+1:0] req_addr,
  input  logic [data_size-1:0] req_wdata,
  output logic                 stall,
  output logic                 rdata_valid,
  output logic [data_size-1:0] rdata,
  output logic                 err,
  output logic                 DM_enable,
  output logic                 DM_read,
  output logic                 DM_write,
  output logic [addr_size-1:0] DM_addr,
  output logic [data_size-1:0] DM_in,
  input  logic [data_size-1:0] DM_out,
  input  logic                 DM_ready,
  input  logic [1:0]           DM_resp,
  input  logic                 DM_finish
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 we_q, we_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic [1:0]           off_q, off_d;
  logic [data_size-1:0] wdata_q, wdata_d;
  logic [addr_size-1:0] addr_q, addr_d;
  logic [data_size-1:0] din_q, din_d;
  logic [data_size-1:0] rdata_q, rdata_d;
  logic                 rv_q, rv_d;
  logic                 err_q, err_d;
  logic [data_size-1:0] ext_data_c, merge_data_c;
  logic                 wait_expired_c;
  logic                 unused_ready;

  assign unused_ready = DM_ready;

  dm_lane_unit #(.data_size(data_size)) u_lane (
    .dm_word      (DM_out),
    .wdata        (wdata_q),
    .offset       (off_q),
    .size         (size_q),
    .is_unsigned  (uns_q),
    .ext_data_c   (ext_data_c),
    .merge_data_c (merge_data_c)
  );

  assign wait_expired_c = (timer_q == TIMER_W'(TIMEOUT - 1));

  assign stall     = req_valid && (state_q != S_DONE);
  assign DM_enable = !rst && ((state_q == S_RD) || (state_q == S_WR));
  assign DM_read   = !rst && (state_q == S_RD);
  assign DM_write  = !rst && (state_q == S_WR);

  assign DM_addr     = addr_q;
  assign DM_in       = din_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rv_q;
  assign err         = err_q;

  // Next-state and register-input logic.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    rv_d    = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          // Request is captured so a dropped req_valid cannot corrupt the access.
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          addr_d  = req_addr[addr_size+1:2];
          timer_d = '0;
          if (is_bad_req(req_size, req_addr[1:0])) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else if (!req_we || (req_size != SZ_W)) begin
            state_d = S_RD;
          end else begin
            din_d   = req_wdata;
            state_d = S_WR;
          end
        end
      end
      S_RD: state_d = S_RWAIT;
      S_RWAIT: begin
        timer_d = timer_q + TIMER_W'(1);
        if (DM_finish) begin
          timer_d = '0;
          if (DM_resp != RESP_OKAY) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else if (!we_q) begin
            rdata_d = ext_data_c;
            rv_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            din_d   = merge_data_c;
            state_d = S_WR;
          end
        end else if (wait_expired_c) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_WR: state_d = S_WWAIT;
      S_WWAIT: begin
        timer_d = timer_q + TIMER_W'(1);
        if (DM_finish) begin
          timer_d = '0;
          state_d = S_DONE;
          err_d   = (DM_resp != RESP_OKAY);
        end else if (wait_expired_c) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_DONE: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      wdata_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl with a one-cycle-latency memory model.
module tb_dm_access_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW+1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          stall;
  logic          rdata_valid;
  logic [DW-1:0] rdata;
  logic          err;
  logic          DM_enable;
  logic          DM_read;
  logic          DM_write;
  logic [AW-1:0] DM_addr;
  logic [DW-1:0] DM_in;
  logic [DW-1:0] DM_out = '0;
  logic          DM_ready = 1'b1;
  logic [1:0]    DM_resp = 2'b00;
  logic          DM_finish = 1'b0;

  always #5 clk = ~clk;

  dm_access_ctrl #(.data_size(DW), .addr_size(AW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .rdata_valid  (rdata_valid),
    .rdata        (rdata),
    .err          (err),
    .DM_enable    (DM_enable),
    .DM_read      (DM_read),
    .DM_write     (DM_write),
    .DM_addr      (DM_addr),
    .DM_in        (DM_in),
    .DM_out       (DM_out),
    .DM_ready     (DM_ready),
    .DM_resp      (DM_resp),
    .DM_finish    (DM_finish)
  );

  // Memory: answers the cycle after an enable unless told to stay silent.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          no_finish = 1'b0;
  logic          resp_err_rd = 1'b0;

  always @(posedge clk) begin
    DM_finish <= 1'b0;
    DM_resp   <= 2'b00;
    if (DM_enable && !no_finish) begin
      DM_finish <= 1'b1;
      if (DM_read) begin
        DM_out <= mem[DM_addr];
        if (resp_err_rd) DM_resp <= 2'b01;
      end
      if (DM_write) mem[DM_addr] <= DM_in;
    end
  end

  typedef struct {
    string         name;
    logic          err;
    logic          rv;
    logic [DW-1:0] rdata;
    int            lat;
    int            en;
    int            wr;
  } exp_t;

  exp_t          sbq[$];
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] model_rdata = '0;
  int            first_wr;

  // Wait for the access to reach DONE, then pop and compare its expectation.
  task automatic collect();
    exp_t e;
    int cyc, en_n, wr_n;
    #1;
    if (!stall) @(negedge clk);
    cyc = 0; en_n = 0; wr_n = 0; first_wr = -1;
    while (stall && cyc < 200) begin
      if (DM_enable) en_n++;
      if (DM_write) begin
        wr_n++;
        if (first_wr < 0) first_wr = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    e = sbq.pop_front();
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL %s done: still stalled after %0d cycles", e.name, cyc); end
    checks++;
    if (cyc + 1 != e.lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", e.name, cyc + 1, e.lat); end
    checks++;
    if (err !== e.err) begin errors++; $display("FAIL %s err: got %b expected %b", e.name, err, e.err); end
    checks++;
    if (rdata_valid !== e.rv) begin errors++; $display("FAIL %s rdata_valid: got %b expected %b", e.name, rdata_valid, e.rv); end
    checks++;
    if (rdata !== e.rdata) begin errors++; $display("FAIL %s rdata: got %08h expected %08h", e.name, rdata, e.rdata); end
    checks++;
    if (en_n != e.en) begin errors++; $display("FAIL %s enables: got %0d expected %0d", e.name, en_n, e.en); end
    checks++;
    if (wr_n != e.wr) begin errors++; $display("FAIL %s writes: got %0d expected %0d", e.name, wr_n, e.wr); end
    req_valid = 1'b0;
  endtask

  // Drive one request, push its expected outcome, then collect it.
  task automatic issue(input string name, input logic we, input logic [1:0] size, input logic uns,
                       input logic [AW+1:0] addr, input logic [DW-1:0] wdata, input logic exp_err,
                       input logic [DW-1:0] load_val, input int lat, input int en, input int wr);
    exp_t e;
    e.name = name;
    e.err  = exp_err;
    e.rv   = !we && !exp_err;
    if (e.rv) model_rdata = load_val;
    e.rdata = model_rdata;
    e.lat   = lat;
    e.en    = en;
    e.wr    = wr;
    sbq.push_back(e);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    collect();
  endtask

  task automatic check_mem(input string name, input int widx, input logic [DW-1:0] exp);
    checks++;
    if (mem[widx] !== exp) begin errors++; $display("FAIL %s mem: got %08h expected %08h", name, mem[widx], exp); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({DM_enable, DM_read, DM_write} !== 3'b000) begin errors++; $display("FAIL reset strobes: got %b expected 000", {DM_enable, DM_read, DM_write}); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall, rdata_valid, err} !== 3'b000) begin errors++; $display("FAIL reset flags: got %b expected 000", {stall, rdata_valid, err}); end
    checks++;
    if (rdata !== '0 || DM_in !== '0 || DM_addr !== '0) begin errors++; $display("FAIL reset data: got rdata=%08h DM_in=%08h DM_addr=%03h expected zeros", rdata, DM_in, DM_addr); end
  endtask

  task automatic test_word();
    issue("sw010", 1'b1, 2'd2, 1'b0, 14'h010, 32'hDEADBEEF, 1'b0, 32'h0, 4, 1, 1);
    checks++;
    if (first_wr != 1) begin errors++; $display("FAIL sw010 write cycle: got %0d expected 1", first_wr); end
    check_mem("sw010", 4, 32'hDEADBEEF);
    issue("lw010", 1'b0, 2'd2, 1'b0, 14'h010, 32'h0, 1'b0, 32'hDEADBEEF, 4, 1, 0);
  endtask

  task automatic test_subword_store();
    issue("sw020", 1'b1, 2'd2, 1'b0, 14'h020, 32'h11223344, 1'b0, 32'h0, 4, 1, 1);
    issue("sb021", 1'b1, 2'd0, 1'b0, 14'h021, 32'h000000AA, 1'b0, 32'h0, 6, 2, 1);
    check_mem("sb021", 8, 32'h1122AA44);
    issue("sh022", 1'b1, 2'd1, 1'b0, 14'h022, 32'h0000BEEF, 1'b0, 32'h0, 6, 2, 1);
    check_mem("sh022", 8, 32'hBEEFAA44);
  endtask

  task automatic test_loads();
    issue("sw030",  1'b1, 2'd2, 1'b0, 14'h030, 32'h80FF7F01, 1'b0, 32'h0, 4, 1, 1);
    issue("lb030",  1'b0, 2'd0, 1'b0, 14'h030, 32'h0, 1'b0, 32'h00000001, 4, 1, 0);
    issue("lb031",  1'b0, 2'd0, 1'b0, 14'h031, 32'h0, 1'b0, 32'h0000007F, 4, 1, 0);
    issue("lb032",  1'b0, 2'd0, 1'b0, 14'h032, 32'h0, 1'b0, 32'hFFFFFFFF, 4, 1, 0);
    issue("lbu032", 1'b0, 2'd0, 1'b1, 14'h032, 32'h0, 1'b0, 32'h000000FF, 4, 1, 0);
    issue("lh032",  1'b0, 2'd1, 1'b0, 14'h032, 32'h0, 1'b0, 32'hFFFF80FF, 4, 1, 0);
    issue("lhu030", 1'b0, 2'd1, 1'b1, 14'h030, 32'h0, 1'b0, 32'h00007F01, 4, 1, 0);
    issue("lbu033", 1'b0, 2'd0, 1'b1, 14'h033, 32'h0, 1'b0, 32'h00000080, 4, 1, 0);
  endtask

  task automatic test_misaligned();
    issue("lw006",  1'b0, 2'd2, 1'b0, 14'h006, 32'h0, 1'b1, 32'h0, 2, 0, 0);
    issue("sh003",  1'b1, 2'd1, 1'b0, 14'h003, 32'h0000CAFE, 1'b1, 32'h0, 2, 0, 0);
    issue("size3",  1'b0, 2'd3, 1'b0, 14'h040, 32'h0, 1'b1, 32'h0, 2, 0, 0);
  endtask

  task automatic test_resp_error();
    resp_err_rd = 1'b1;
    issue("sb_resp", 1'b1, 2'd0, 1'b0, 14'h020, 32'h00000055, 1'b1, 32'h0, 4, 1, 0);
    issue("lw_resp", 1'b0, 2'd2, 1'b0, 14'h030, 32'h0, 1'b1, 32'h0, 4, 1, 0);
    resp_err_rd = 1'b0;
    check_mem("sb_resp", 8, 32'hBEEFAA44);
  endtask

  task automatic test_timeout();
    no_finish = 1'b1;
    issue("lw_to", 1'b0, 2'd2, 1'b0, 14'h010, 32'h0, 1'b1, 32'h0, 3 + TO, 1, 0);
    issue("sw_to", 1'b1, 2'd2, 1'b0, 14'h060, 32'h01020304, 1'b1, 32'h0, 3 + TO, 1, 1);
    no_finish = 1'b0;
  endtask

  task automatic test_rst_mid_access();
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 14'h050; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (DM_write !== 1'b1) begin errors++; $display("FAIL rst_wr write strobe: got %b expected 1", DM_write); end
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({DM_enable, rdata_valid, err} !== 3'b000) begin errors++; $display("FAIL rst_wwait flags: got %b expected 000", {DM_enable, rdata_valid, err}); end
    checks++;
    if (rdata !== '0 || DM_in !== '0 || DM_addr !== '0) begin errors++; $display("FAIL rst_wwait data: got rdata=%08h DM_in=%08h DM_addr=%03h expected zeros", rdata, DM_in, DM_addr); end
    model_rdata = '0;
    // Reset during the read strobe cycle must gate the strobes immediately.
    req_we = 1'b0; req_size = 2'd2; req_addr = 14'h010; req_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (DM_read !== 1'b1) begin errors++; $display("FAIL rst_rd read strobe: got %b expected 1", DM_read); end
    rst = 1'b1;
    #1;
    checks++;
    if ({DM_enable, DM_read} !== 2'b00) begin errors++; $display("FAIL rst_rd gated strobes: got %b expected 00", {DM_enable, DM_read}); end
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    issue("lw_after_rst", 1'b0, 2'd2, 1'b0, 14'h010, 32'h0, 1'b0, 32'hDEADBEEF, 4, 1, 0);
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword_store();
    test_loads();
    test_misaligned();
    test_resp_error();
    test_timeout();
    test_rst_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
